ttm4_sequencer: RTL and testbench

Instruction sequencer and register file for the TTM4 4-bit CPU. It fetches 8-bit instructions from an external 16-word program ROM and drives the ALU's load bus, immediate, Y operand, SEL and active-low unit enables. It writes the ALU store-bus result back into register A or B, and branches on the ALU carry flag. It sits opposite the ALU on the LOADBUS/STOREBUS pair: it writes LOADBUS and reads STOREBUS.

---
 rtl/ttm4_pkg.sv | 28 ++
 rtl/ttm4_decoder.sv | 56 +++++
 rtl/ttm4_sequencer.sv | 106 ++++++++++
 tb/tb_ttm4_sequencer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ttm4_pkg.sv
// Shared opcode, FSM state and field-width definitions for the TTM4 sequencer.
// TTM4_STEP_EN adds a WAIT state ahead of FETCH for single-stepping.
package ttm4_pkg;

    localparam int OP_W    = 3;
    localparam int DATA_W  = 4;
    localparam int ADDR_W  = 4;
    localparam int INSTR_W = 8;

    localparam logic [OP_W-1:0] OP_ADDI = 3'd0;
    localparam logic [OP_W-1:0] OP_SUBI = 3'd1;
    localparam logic [OP_W-1:0] OP_ADD  = 3'd2;
    localparam logic [OP_W-1:0] OP_ANDI = 3'd3;
    localparam logic [OP_W-1:0] OP_ORI  = 3'd4;
    localparam logic [OP_W-1:0] OP_XORI = 3'd5;
    localparam logic [OP_W-1:0] OP_IO   = 3'd6;
    localparam logic [OP_W-1:0] OP_JMP  = 3'd7;

`ifdef TTM4_STEP_EN
    typedef enum logic [1:0] {S_FETCH, S_DECODE, S_EXEC, S_WAIT} state_t;
    // State entered after reset and after every EXEC.
    localparam state_t S_RESUME = S_WAIT;
`else
    typedef enum logic [1:0] {S_FETCH, S_DECODE, S_EXEC} state_t;
    localparam state_t S_RESUME = S_FETCH;
`endif

endpackage

// File: rtl/ttm4_decoder.sv
// Instruction decoder: IR + EXEC qualifier -> ALU controls, write enables, jump-taken.
// Latency: combinational. Backpressure: none; all controls idle outside EXEC.
// Jump condition reads the ALU carry, which the ALU updates only on FA ops.
module ttm4_decoder
    import ttm4_pkg::*;
(
    input  logic [INSTR_W-1:0] ir,
    input  logic               exec,
    input  logic               c_flag,
    output logic [1:0]         sel,
    output logic               n_fa_en,
    output logic               n_and_en,
    output logic               n_or_en,
    output logic               n_xor_en,
    output logic [DATA_W-1:0]  im,
    output logic               alu_we,
    output logic               in_we,
    output logic               out_we,
    output logic               jump_taken
);

    logic [OP_W-1:0] op;
    assign op = ir[INSTR_W-1 -: OP_W];

    always_comb begin
        sel        = 2'b00;
        n_fa_en    = 1'b1;
        n_and_en   = 1'b1;
        n_or_en    = 1'b1;
        n_xor_en   = 1'b1;
        im         = '0;
        alu_we     = 1'b0;
        in_we      = 1'b0;
        out_we     = 1'b0;
        jump_taken = 1'b0;
        if (exec) begin
            im = ir[DATA_W-1:0];
            case (op)
                OP_ADDI: begin n_fa_en  = 1'b0; alu_we = 1'b1; end
                OP_SUBI: begin n_fa_en  = 1'b0; sel = 2'b10; alu_we = 1'b1; end
                OP_ADD:  begin n_fa_en  = 1'b0; sel = 2'b01; alu_we = 1'b1; end
                OP_ANDI: begin n_and_en = 1'b0; alu_we = 1'b1; end
                OP_ORI:  begin n_or_en  = 1'b0; alu_we = 1'b1; end
                OP_XORI: begin n_xor_en = 1'b0; alu_we = 1'b1; end
                OP_IO: begin
                    in_we  = ir[4];
                    out_we = !ir[4];
                end
                // r=0 is an unconditional JMP, r=1 is JNC
                OP_JMP:  jump_taken = !ir[4] || !c_flag;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ttm4_sequencer.sv
// TTM4 sequencer: fetch/decode/exec FSM, PC, IR, registers A/B and OUT_PORT.
// Latency: 3 cycles per instruction (4 with TTM4_STEP_EN and STEP held high).
// Backpressure: none; TTM4_STEP_EN holds in WAIT until STEP is sampled high.
module ttm4_sequencer
    import ttm4_pkg::*;
(
    input  logic               CLK,
    input  logic               RST,
`ifdef TTM4_STEP_EN
    input  logic               STEP,
`endif
    output logic [ADDR_W-1:0]  ROM_ADDR,
    input  logic [INSTR_W-1:0] ROM_DATA,
    output logic [DATA_W-1:0]  LOADBUS,
    input  logic [DATA_W-1:0]  STOREBUS,
    output logic [DATA_W-1:0]  IM,
    output logic [DATA_W-1:0]  Y,
    output logic [1:0]         SEL,
    output logic               nFA_EN,
    output logic               nAND_EN,
    output logic               nOR_EN,
    output logic               nXOR_EN,
    input  logic               C_FLAG,
    input  logic               Z_FLAG,
    input  logic [DATA_W-1:0]  IN_PORT,
    output logic [DATA_W-1:0]  OUT_PORT,
    output logic               RETIRE
);

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   pc;
    logic [INSTR_W-1:0]  ir;
    logic [DATA_W-1:0]   reg_a;
    logic [DATA_W-1:0]   reg_b;
    logic                exec;
    logic                alu_we;
    logic                in_we;
    logic                out_we;
    logic                jump_taken;
    logic                unused_z;

    assign unused_z = Z_FLAG;

    // Reset aborts an in-flight EXEC: no ALU drive, no write-back, no RETIRE.
    assign exec     = (state == S_EXEC) && !RST;
    assign RETIRE   = exec;
    assign ROM_ADDR = pc;
    assign LOADBUS  = ir[4] ? reg_b : reg_a;
    assign Y        = ir[4] ? reg_a : reg_b;

    ttm4_decoder u_decoder (
        .ir         (ir),
        .exec       (exec),
        .c_flag     (C_FLAG),
        .sel        (SEL),
        .n_fa_en    (nFA_EN),
        .n_and_en   (nAND_EN),
        .n_or_en    (nOR_EN),
        .n_xor_en   (nXOR_EN),
        .im         (IM),
        .alu_we     (alu_we),
        .in_we      (in_we),
        .out_we     (out_we),
        .jump_taken (jump_taken)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: state_nxt = S_EXEC;
            S_EXEC:   state_nxt = S_RESUME;
`ifdef TTM4_STEP_EN
            S_WAIT:   state_nxt = STEP ? S_FETCH : S_WAIT;
`endif
            default:  state_nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= S_RESUME;
            pc       <= '0;
            ir       <= '0;
            reg_a    <= '0;
            reg_b    <= '0;
            OUT_PORT <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_DECODE) begin
                ir <= ROM_DATA;
            end
            if (exec) begin
                if (alu_we) begin
                    if (ir[4]) reg_b <= STOREBUS;
                    else       reg_a <= STOREBUS;
                end
                if (in_we)  reg_a    <= IN_PORT;
                if (out_we) OUT_PORT <= reg_a;
                pc <= jump_taken ? ir[ADDR_W-1:0] : pc + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_ttm4_sequencer.sv
// Bench: ROM + ALU models around the sequencer, ISA-level reference model, scoreboard.
`timescale 1ns/1ps
module tb_ttm4_sequencer;

`ifdef TTM4_STEP_EN
    localparam int CPI = 4;
`else
    localparam int CPI = 3;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       step;
    logic [3:0] rom_addr;
    logic [7:0] rom_data;
    logic [3:0] loadbus, storebus, im, y, in_port, out_port;
    logic [1:0] sel;
    logic       n_fa, n_and, n_or, n_xor, c_flag, retire;
    logic       z_flag;

    always #5 clk = ~clk;

    ttm4_sequencer dut (
        .CLK(clk), .RST(rst),
`ifdef TTM4_STEP_EN
        .STEP(step),
`endif
        .ROM_ADDR(rom_addr), .ROM_DATA(rom_data),
        .LOADBUS(loadbus), .STOREBUS(storebus), .IM(im), .Y(y), .SEL(sel),
        .nFA_EN(n_fa), .nAND_EN(n_and), .nOR_EN(n_or), .nXOR_EN(n_xor),
        .C_FLAG(c_flag), .Z_FLAG(z_flag),
        .IN_PORT(in_port), .OUT_PORT(out_port), .RETIRE(retire)
    );

    // Synchronous program ROM: data for an address is valid one cycle later.
    logic [7:0] rom [16];
    always @(posedge clk) rom_data <= rom[rom_addr];

    // External ALU: combinational result, carry registered on FA ops.
    logic [3:0] alu_b;
    logic [4:0] alu_sum;
    always_comb begin
        alu_b = sel[0] ? y : im;
        if (sel[1]) alu_b = ~alu_b;
        alu_sum  = {1'b0, loadbus} + {1'b0, alu_b} + {4'd0, sel[1]};
        storebus = 4'd0;
        if (!n_fa)       storebus = alu_sum[3:0];
        else if (!n_and) storebus = loadbus & alu_b;
        else if (!n_or)  storebus = loadbus | alu_b;
        else if (!n_xor) storebus = loadbus ^ alu_b;
        z_flag = (storebus == 4'd0);
    end
    always @(posedge clk) begin
        if (rst)        c_flag <= 1'b0;
        else if (!n_fa) c_flag <= alu_sum[4];
    end

    typedef struct {
        logic [3:0] pc, ld, y, im;
        logic [1:0] sel;
        logic [3:0] en;
        logic [3:0] npc, post_ld, post_y, out;
    } exp_t;

    exp_t eq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   mon_en = 1'b0;

    // Architectural state of the reference model.
    int m_pc, m_a, m_b, m_c, m_out;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_pc = 0; m_a = 0; m_b = 0; m_c = 0; m_out = 0;
    endfunction

    // Executes one instruction at ISA level and returns what the DUT should show.
    function automatic exp_t model_step(input logic [7:0] instr, input logic [3:0] inp);
        exp_t e;
        int op, r, imm, rd, rs, res, npc;
        bit wr;
        op  = int'(instr[7:5]);
        r   = int'(instr[4]);
        imm = int'(instr[3:0]);
        rd  = r ? m_b : m_a;
        rs  = r ? m_a : m_b;
        e.pc = 4'(m_pc); e.ld = 4'(rd); e.y = 4'(rs);
        e.im = 4'(imm); e.sel = 2'b00; e.en = 4'b1111;
        wr = 1'b0; res = rd;
        npc = (m_pc + 1) % 16;
        case (op)
            0: begin e.en = 4'b0111; res = (rd + imm) % 16; m_c = int'(rd + imm > 15); wr = 1; end
            1: begin e.en = 4'b0111; e.sel = 2'b10; res = (rd + 16 - imm) % 16;
                     m_c = int'(rd >= imm); wr = 1; end
            2: begin e.en = 4'b0111; e.sel = 2'b01; res = (rd + rs) % 16;
                     m_c = int'(rd + rs > 15); wr = 1; end
            3: begin e.en = 4'b1011; res = rd & imm; wr = 1; end
            4: begin e.en = 4'b1101; res = rd | imm; wr = 1; end
            5: begin e.en = 4'b1110; res = rd ^ imm; wr = 1; end
            6: begin if (r == 0) m_out = m_a; else m_a = int'(inp); end
            default: begin if (r == 0 || m_c == 0) npc = imm; end
        endcase
        if (wr) begin
            if (r == 1) m_b = res; else m_a = res;
        end
        e.post_ld = 4'(r ? m_b : m_a);
        e.post_y  = 4'(r ? m_a : m_b);
        e.out     = 4'(m_out);
        e.npc     = 4'(npc);
        m_pc      = npc;
        return e;
    endfunction

    // Monitor: captures each retiring instruction and the following cycle, then scores.
    initial begin : monitor
        int   since;
        bit   have;
        exp_t e;
        logic [3:0] a_pc, a_ld, a_y, a_im, a_en;
        logic [1:0] a_sel;
        have = 0; since = 0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                have = 0;
            end else begin
                since++;
                if (retire) begin
                    if (have) chk("cycles_per_instr", since, CPI);
                    have = 1; since = 0;
                    a_pc = rom_addr; a_ld = loadbus; a_y = y; a_im = im; a_sel = sel;
                    a_en = {n_fa, n_and, n_or, n_xor};
                    @(negedge clk);
                    since++;
                    chk("idle_ctrl_after_exec", {retire, n_fa, n_and, n_or, n_xor, sel, im},
                        {1'b0, 4'b1111, 2'b00, 4'd0});
                    if (eq.size() == 0) begin
                        chk("unexpected_retire", 1, 0);
                    end else begin
                        e = eq.pop_front();
                        chk("exec_pc", a_pc, e.pc);
                        chk("exec_loadbus", a_ld, e.ld);
                        chk("exec_y", a_y, e.y);
                        chk("exec_im", a_im, e.im);
                        chk("exec_sel", a_sel, e.sel);
                        chk("exec_enables", a_en, e.en);
                        chk("next_pc", rom_addr, e.npc);
                        chk("post_loadbus", loadbus, e.post_ld);
                        chk("post_y", y, e.post_y);
                        chk("out_port", out_port, e.out);
                    end
                end else begin
                    chk("idle_ctrl", {n_fa, n_and, n_or, n_xor, sel, im}, {4'b1111, 2'b00, 4'd0});
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    // Issues n instructions: sets IN_PORT, pushes expectation, waits for RETIRE.
    task automatic run_prog(input int n, input bit rand_in);
        bit got;
        mon_en = 1'b1;
        for (int k = 0; k < n; k++) begin
            in_port = rand_in ? 4'($urandom_range(0, 15)) : 4'hA;
            eq.push_back(model_step(rom[m_pc[3:0]], in_port));
            got = 1'b0;
            for (int t = 0; t < 10 && !got; t++) begin
                @(negedge clk);
                got = retire;
            end
            if (!got) begin
                chk("retire_timeout", 0, 1);
                break;
            end
            @(posedge clk);
            #1;
        end
        repeat (2) @(posedge clk);
        #1 mon_en = 1'b0;
        chk("scoreboard_drained", eq.size(), 0);
        eq.delete();
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        logic [7:0] prog [16];
        step = 1'b1;
        in_port = 4'd0;
        rst = 1'b1;
        for (int i = 0; i < 16; i++) rom[i] = 8'h00;

        // Reset values.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_out_port", out_port, 0);
        chk("rst_loadbus_y", {loadbus, y}, 0);
        chk("rst_retire", retire, 0);
        chk("rst_ctrl", {n_fa, n_and, n_or, n_xor, sel, im}, {4'b1111, 2'b00, 4'd0});

        // Directed program: arithmetic, borrow-driven JNC, I/O, register ADD, PC wrap.
        prog = '{8'h03, 8'h21, 8'h23, 8'hF5, 8'h00, 8'hD0, 8'hC0, 8'h16,
                 8'h26, 8'h40, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 16; i++) rom[i] = prog[i];
        do_reset();
        run_prog(13, 1'b0);

`ifdef TTM4_STEP_EN
        // With STEP low the sequencer must stay parked at address 0.
        step = 1'b0;
        do_reset();
        begin
            int bad;
            bad = 0;
            repeat (8) begin
                @(negedge clk);
                if (retire || rom_addr != 4'd0 || loadbus != 4'd0) bad++;
            end
            chk("step_hold", bad, 0);
        end
        step = 1'b1;
`endif

        // Reset asserted during EXEC of ADDI A,3 aborts it.
        rom[0] = 8'h03;
        do_reset();
        repeat (CPI - 1) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("abort_retire", retire, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_pc", rom_addr, 0);
        chk("abort_reg_a", loadbus, 0);
        chk("abort_no_retire", retire, 0);
        model_reset();
        run_prog(3, 1'b1);

        // Random programs with random input-port values.
        for (int p = 0; p < 6; p++) begin
            for (int i = 0; i < 16; i++) rom[i] = 8'($urandom_range(0, 255));
            do_reset();
            run_prog(40, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
